somador_serial_ctrl: RTL and testbench
======================================

# somador_serial_ctrl

Bit-serial N-bit adder controller that sequences a single 1-bit full-adder datapath (two half-adder cells plus an OR on the carries) over N clock cycles, LSB first. Operands are captured on a start request. Partial sums are shifted into an internal register, and the final sum and carry are presented with a one-cycle completion pulse. The block lets wide additions share one small adder cell instead of instantiating an N-bit ripple chain.

## Interface
- `N`, default 8: operand width in bits; legal range 1 to 32.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst_n`  in  1: reset; synchronous, active-low.
- `inicio`  in  1: start request; sampled only in OCIOSO.
- `A`  in  N: operand A; captured on the accepting edge.
- `B`  in  N: operand B; captured on the accepting edge.
- `S`  out  N: registered sum; updated only on entry to FIM.
- `Cout`  out  1: registered carry out; updated with `S`.
- `pronto`  out  1: completion pulse, high for exactly one cycle in FIM.
- `ocupado`  out  1: high in SOMA and FIM.
- `ovf`  out  1: signed overflow; exists only when `SOMADOR_SERIAL_OVF_EN` is defined.

## Operation
- States:
  - OCIOSO: idle.
  - SOMA: one bit processed per cycle.
  - FIM: result presentation.
- Internal registers:
  - `ra`, `rb` (N): operand shift registers.
  - `rs` (N): partial-sum shift register.
  - `c` (1): running carry.
  - `cnt`: $clog2(N+1) bits.
- OCIOSO -> SOMA when `inicio`=1 at an edge:
  - `ra`<=`A`, `rb`<=`B`, `c`<=0, `cnt`<=0.
- SOMA, every edge:
  - Sum bit `s` = `ra[0]`^`rb[0]`^`c` (half adder 1: `ra[0]`,`rb[0]`; half adder 2: its sum and `c`).
  - `c` <= OR of both half-adder carries.
  - `rs` <= {`s`, `rs[N-1:1]`}.
  - `ra` and `rb` shift right by one.
  - `cnt`++.
- SOMA -> FIM on the edge where `cnt`=N-1:
  - The final bit is processed on that same edge.
  - `S` <= final shifted `rs`; `Cout` <= final carry.
- FIM -> OCIOSO unconditionally on the next edge.
- `inicio` is ignored in SOMA and FIM; there is no queueing.
- Arithmetic: `S` = (`A`+`B`) mod 2^N; `Cout` = bit N of the sum.
- Reset (`rst_n`=0 at an edge), from any state including mid-SOMA:
  - State -> OCIOSO.
  - `S`=0, `Cout`=0, `pronto`=0, `ocupado`=0, `ovf`=0; internal registers cleared.
  - The in-flight operation is discarded and produces no `pronto`.
- Reset has priority over `inicio` at the same edge.

## Timing
- Let t0 be the edge accepting `inicio`.
  - Bit i is processed at edge t0+1+i.
  - Edge t0+N: enter FIM; `S`, `Cout` (and `ovf`) valid from this edge; `pronto`=1.
  - Edge t0+N+1: return to OCIOSO; `pronto`=0, `ocupado`=0.
- Latency from accepting edge to `pronto`: N cycles. Throughput: one addition per N+2 cycles.
- Back-to-back: holding `inicio`=1 starts the next operation at edge t0+N+2.
- `ocupado` is high after edges t0 through t0+N; low after t0+N+1.
- `S`/`Cout` hold their last completed value through OCIOSO and SOMA until the next FIM.
- N=1: SOMA lasts one cycle; `pronto` follows the accepting edge by 1 cycle.

## Configuration
- Macro `SOMADOR_SERIAL_OVF_EN`.
- Defined:
  - Port `ovf` exists.
  - On FIM entry, `ovf` <= (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow.
  - `ovf` is held with `S`; reset value 0.
  - The carry into the MSB is captured during the bit processed at edge t0+N.
- Undefined: no `ovf` port and no extra registers; all other behaviour is identical.

## Test plan
- N=8, reset then `A`=0x00, `B`=0x00, `inicio` pulse -> `pronto` 8 cycles later; `S`=0x00, `Cout`=0; `ocupado` high for 9 cycles.
- N=8, `A`=0xFF, `B`=0x01 -> `S`=0x00, `Cout`=1; `A`=0x5A, `B`=0x3C -> `S`=0x96, `Cout`=0.
- N=8 with `SOMADOR_SERIAL_OVF_EN`:
  - `A`=0x7F, `B`=0x01 -> `S`=0x80, `ovf`=1.
  - `A`=0xFF, `B`=0xFF -> `S`=0xFE, `Cout`=1, `ovf`=0.
- N=8, `rst_n`=0 at edge t0+4 of an operation -> all outputs 0, no `pronto`.
  - Then a new `inicio` with `A`=0x10, `B`=0x20 -> `S`=0x30.
- N=8, `inicio` re-pulsed with different operands during SOMA and during FIM -> ignored; original result delivered.
  - With `inicio` held high continuously, consecutive `pronto` pulses are 10 cycles apart.
- N=1, all four (`A`,`B`) combinations -> half-adder truth table:
  - 0+0 -> `S`=0, `Cout`=0.
  - 0+1 -> `S`=1, `Cout`=0.
  - 1+0 -> `S`=1, `Cout`=0.
  - 1+1 -> `S`=0, `Cout`=1.
  - `pronto` 1 cycle after each accepting edge.

Source files
------------

// File: rtl/somador_serial_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell (two half adders + OR) stepped LSB-first over N cycles.
// Optional signed-overflow output enabled by defining SOMADOR_SERIAL_OVF_EN.

module somador_meio (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module somador_serial_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         pronto,
    output logic         ocupado
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    typedef enum logic [1:0] {OCIOSO, SOMA, FIM} estado_t;

    estado_t        estado, estado_nxt;
    logic [N-1:0]   ra, rb, rs, rs_nxt;
    logic           c, c_nxt;
    logic [CW-1:0]  cnt;
    logic           s1, c1, s_bit, c2, ultimo;

    somador_meio u_meio_a (.x(ra[0]), .y(rb[0]), .s(s1),    .c(c1));
    somador_meio u_meio_b (.x(s1),    .y(c),     .s(s_bit), .c(c2));

    // Concatenate-then-shift keeps the N=1 case free of a reversed slice.
    always_comb begin
        c_nxt  = c1 | c2;
        rs_nxt = N'({s_bit, rs} >> 1);
        ultimo = (cnt == ULTIMO);
    end

    always_comb begin
        estado_nxt = estado;
        case (estado)
            OCIOSO:  if (inicio) estado_nxt = SOMA;
            SOMA:    if (ultimo) estado_nxt = FIM;
            FIM:     estado_nxt = OCIOSO;
            default: estado_nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= estado_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            rs   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            S    <= '0;
            Cout <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            case (estado)
                OCIOSO: if (inicio) begin
                    ra  <= A;
                    rb  <= B;
                    c   <= 1'b0;
                    cnt <= '0;
                end
                SOMA: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= rs_nxt;
                    c   <= c_nxt;
                    cnt <= cnt + CW'(1);
                    // Last bit: c is the carry into the MSB, c_nxt the carry out.
                    if (ultimo) begin
                        S    <= rs_nxt;
                        Cout <= c_nxt;
`ifdef SOMADOR_SERIAL_OVF_EN
                        ovf  <= c ^ c_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign pronto  = (estado == FIM);
    assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Directed bench for somador_serial_ctrl (N=8 and N=1 instances) with a queue scoreboard.
// Also checks ovf when SOMADOR_SERIAL_OVF_EN is defined.

module tb_somador_serial_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       inicio8, inicio1;
    logic [7:0] A8, B8, S8;
    logic [0:0] A1, B1, S1;
    logic       Cout8, pronto8, ocupado8, Cout1, pronto1, ocupado1;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic       ovf8, ovf1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sb8[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    somador_serial_ctrl #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio8), .A(A8), .B(B8),
        .S(S8), .Cout(Cout8), .pronto(pronto8), .ocupado(ocupado8)
`ifdef SOMADOR_SERIAL_OVF_EN
        , .ovf(ovf8)
`endif
    );

    somador_serial_ctrl #(.N(1)) u1 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio1), .A(A1), .B(B1),
        .S(S1), .Cout(Cout1), .pronto(pronto1), .ocupado(ocupado1)
`ifdef SOMADOR_SERIAL_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic [8:0] sum;
        logic [7:0] m;
        m     = (w == 8) ? 8'hFF : 8'h01;
        sum   = {1'b0, a & m} + {1'b0, b & m};
        e.s   = sum[7:0] & m;
        e.c   = sum[w];
        e.o   = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic sb8_check(input string tag);
        exp_t e;
        if (sb8.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb8.pop_front();
        check({tag, "_S"}, S8, e.s);
        check({tag, "_Cout"}, Cout8, e.c);
`ifdef SOMADOR_SERIAL_OVF_EN
        check({tag, "_ovf"}, ovf8, e.o);
`endif
    endtask

    // One N=8 operation; optional re-pulses of inicio in SOMA and in FIM must be ignored.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input bit inj_soma, input bit inj_fim);
        int k, lat, busy;
        bit seen;
        @(negedge clk);
        A8 = a; B8 = b; inicio8 = 1'b1;
        sb8.push_back(model(8, a, b));
        k = 0; lat = 0; busy = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            inicio8 = inj_soma && (k == 3);
            A8 = ~a;
            B8 = a ^ b ^ 8'h33;
            if (ocupado8) busy++;
            if (pronto8) begin seen = 1; lat = k; end
        end
        check({tag, "_pronto_seen"}, seen, 1);
        check({tag, "_latency"}, lat, 9);
        check({tag, "_ocupado_cycles"}, busy, 9);
        if (seen) sb8_check(tag);
        else if (sb8.size() > 0) void'(sb8.pop_front());
        if (inj_fim) inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        check({tag, "_idle_pronto"}, pronto8, 0);
        check({tag, "_idle_ocupado"}, ocupado8, 0);
    endtask

    initial begin
        int first, second, k, lat;
        bit seen;
        exp_t e;

        rst_n = 1'b0; inicio8 = 1'b0; inicio1 = 1'b0;
        A8 = 8'h00; B8 = 8'h00; A1 = 1'b0; B1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_S", S8, 0);
        check("rst_Cout", Cout8, 0);
        check("rst_pronto", pronto8, 0);
        check("rst_ocupado", ocupado8, 0);
        check("rst1_pronto", pronto1, 0);
`ifdef SOMADOR_SERIAL_OVF_EN
        check("rst_ovf", ovf8, 0);
`endif
        rst_n = 1'b1;

        op8("zero",  8'h00, 8'h00, 0, 0);
        op8("ff_01", 8'hFF, 8'h01, 0, 0);
        op8("5a_3c", 8'h5A, 8'h3C, 0, 0);
        op8("7f_01", 8'h7F, 8'h01, 0, 0);
        op8("80_80", 8'h80, 8'h80, 0, 0);
        for (int i = 0; i < 3; i++)
            op8("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0);
        op8("ff_ff", 8'hFF, 8'hFF, 0, 0);

        // Reset asserted so that it is sampled at edge t0+4 of an operation.
        @(negedge clk);
        A8 = 8'hC3; B8 = 8'h5A; inicio8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_S", S8, 0);
        check("midrst_Cout", Cout8, 0);
        check("midrst_pronto", pronto8, 0);
        check("midrst_ocupado", ocupado8, 0);
`ifdef SOMADOR_SERIAL_OVF_EN
        check("midrst_ovf", ovf8, 0);
`endif
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (pronto8) seen = 1;
        end
        check("midrst_no_pronto", seen, 0);
        op8("after_rst", 8'h10, 8'h20, 0, 0);

        op8("inj_soma_fim", 8'h6B, 8'h2C, 1, 1);

        // inicio held high: pronto pulses every N+2 cycles.
        @(negedge clk);
        A8 = 8'h81; B8 = 8'h92; inicio8 = 1'b1;
        sb8.push_back(model(8, 8'h81, 8'h92));
        sb8.push_back(model(8, 8'h81, 8'h92));
        first = -1; second = -1; k = 0;
        while (second < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (pronto8) begin
                if (first < 0) first = k; else second = k;
                sb8_check("b2b");
            end
        end
        inicio8 = 1'b0;
        check("b2b_gap", second - first, 10);
        repeat (3) @(negedge clk);
        sb8.delete();

        // N=1: half-adder truth table, pronto one cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A1 = i[1]; B1 = i[0]; inicio1 = 1'b1;
            sb1.push_back(model(1, {7'd0, A1}, {7'd0, B1}));
            k = 0; seen = 0; lat = 0;
            while (!seen && k < 6) begin
                @(negedge clk);
                k++;
                inicio1 = 1'b0;
                if (pronto1) begin seen = 1; lat = k; end
            end
            check("n1_latency", lat, 2);
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                check("n1_S", S1, e.s[0]);
                check("n1_Cout", Cout1, e.c);
`ifdef SOMADOR_SERIAL_OVF_EN
                check("n1_ovf", ovf1, e.o);
`endif
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
